// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: samples a multiplexed 4-digit 7-segment display bus
// (active-low anodes/cathodes), captures each digit once it has been
// stable for STABLE_CYC cycles, decodes the glyph to hex, and publishes
// complete four-digit frames. A watchdog flags loss of scanning activity.
// Optional feature: define SEG_FRAME_COMPARE_EN to publish a frame only
// when it matches the previously completed frame.
module seg_scan_decoder #(
   parameter int STABLE_CYC  = 4,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] anodos,
   input  logic [7:0] catodos,
   output logic [3:0] digit3,
   output logic [3:0] digit2,
   output logic [3:0] digit1,
   output logic [3:0] digit0,
   output logic [3:0] dp_out,
   output logic [3:0] blank,
   output logic [3:0] pattern_err,
   output logic       frame_valid,
   output logic       scan_lost
);

   // Decode active-low segments g..a into {err, blank, value}.
   function automatic logic [5:0] seg_decode(input logic [6:0] seg_n);
      logic [5:0] res;
      case (seg_n)
         7'h40:   res = 6'h00;
         7'h79:   res = 6'h01;
         7'h24:   res = 6'h02;
         7'h30:   res = 6'h03;
         7'h19:   res = 6'h04;
         7'h12:   res = 6'h05;
         7'h02:   res = 6'h06;
         7'h78:   res = 6'h07;
         7'h00:   res = 6'h08;
         7'h10:   res = 6'h09;
         7'h08:   res = 6'h0A;
         7'h03:   res = 6'h0B;
         7'h46:   res = 6'h0C;
         7'h21:   res = 6'h0D;
         7'h06:   res = 6'h0E;
         7'h0E:   res = 6'h0F;
         7'h7F:   res = 6'b01_0000;
         default: res = 6'b10_0000;
      endcase
      return res;
   endfunction

   logic [11:0]      r_prev_sample;
   logic [7:0]       r_stab_cnt;
   logic [15:0]      r_to_cnt;
   logic [3:0]       r_mask;
   logic [3:0][3:0]  r_sh_val;
   logic [3:0]       r_sh_dp;
   logic [3:0]       r_sh_blank;
   logic [3:0]       r_sh_err;

   logic [11:0]      w_sample;
   logic             w_same;
   logic             w_onehot;
   logic [1:0]       w_idx;
   logic             w_capture;
   logic             w_lost;
   logic             w_complete;
   logic             w_publish;
   logic [3:0]       w_mask_nxt;
   logic [5:0]       w_dec;

   assign w_sample = {anodos, catodos};
   assign w_same   = (w_sample == r_prev_sample);
   assign w_dec    = seg_decode(catodos[6:0]);
   assign w_lost   = (r_to_cnt >= 16'(TIMEOUT_CYC));
   assign scan_lost = w_lost;
   assign w_complete = (r_mask == 4'hF);
   // Capture fires on the cycle the stability counter reaches STABLE_CYC,
   // so it happens once per stable period.
   assign w_capture = w_same && w_onehot && (r_stab_cnt == 8'(STABLE_CYC - 1));

   // Map a one-hot-low anode pattern to its digit index.
   always_comb begin
      w_onehot = 1'b1;
      w_idx    = 2'd0;
      case (anodos)
         4'b1110: w_idx = 2'd0;
         4'b1101: w_idx = 2'd1;
         4'b1011: w_idx = 2'd2;
         4'b0111: w_idx = 2'd3;
         default: w_onehot = 1'b0;
      endcase
   end

   // Next captured-mask: cleared on publish or watchdog, then the new capture is added.
   always_comb begin
      w_mask_nxt = r_mask;
      if (w_complete || w_lost) w_mask_nxt = 4'h0;
      if (w_capture) w_mask_nxt[w_idx] = 1'b1;
   end

   // Input stability tracking.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_prev_sample <= '0;
         r_stab_cnt    <= '0;
      end else begin
         r_prev_sample <= w_sample;
         if (!w_same) r_stab_cnt <= '0;
         else if (r_stab_cnt != 8'(STABLE_CYC)) r_stab_cnt <= r_stab_cnt + 8'd1;
      end
   end

   // Watchdog: cleared by any capture, otherwise counts up to TIMEOUT_CYC.
   always_ff @(posedge clock) begin
      if (reset) r_to_cnt <= '0;
      else if (w_capture) r_to_cnt <= '0;
      else if (!w_lost) r_to_cnt <= r_to_cnt + 16'd1;
   end

   // Shadow capture of decoded digits and the captured mask.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_mask     <= '0;
         r_sh_val   <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
         r_sh_err   <= '0;
      end else begin
         r_mask <= w_mask_nxt;
         if (w_capture) begin
            r_sh_val[w_idx]   <= w_dec[3:0];
            r_sh_dp[w_idx]    <= ~catodos[7];
            r_sh_blank[w_idx] <= w_dec[4];
            r_sh_err[w_idx]   <= w_dec[5];
         end
      end
   end

`ifdef SEG_FRAME_COMPARE_EN
   logic [3:0][3:0] r_ref_val;
   logic [3:0]      r_ref_dp;
   logic [3:0]      r_ref_blank;
   logic [3:0]      r_ref_err;
   logic            r_ref_vld;

   assign w_publish = w_complete && r_ref_vld && (r_ref_val == r_sh_val) &&
                      (r_ref_dp == r_sh_dp) && (r_ref_blank == r_sh_blank) &&
                      (r_ref_err == r_sh_err);

   // Reference frame: every completed frame becomes the next comparison target.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ref_val   <= '0;
         r_ref_dp    <= '0;
         r_ref_blank <= '0;
         r_ref_err   <= '0;
         r_ref_vld   <= 1'b0;
      end else if (w_complete) begin
         r_ref_val   <= r_sh_val;
         r_ref_dp    <= r_sh_dp;
         r_ref_blank <= r_sh_blank;
         r_ref_err   <= r_sh_err;
         r_ref_vld   <= 1'b1;
      end else if (w_lost) begin
         r_ref_vld   <= 1'b0;
      end
   end
`else
   assign w_publish = w_complete;
`endif

   // Publish shadows to the outputs with a one-cycle frame_valid pulse.
   always_ff @(posedge clock) begin
      if (reset) begin
         digit0      <= '0;
         digit1      <= '0;
         digit2      <= '0;
         digit3      <= '0;
         dp_out      <= '0;
         blank       <= '0;
         pattern_err <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= w_publish;
         if (w_publish) begin
            digit0      <= r_sh_val[0];
            digit1      <= r_sh_val[1];
            digit2      <= r_sh_val[2];
            digit3      <= r_sh_val[3];
            dp_out      <= r_sh_dp;
            blank       <= r_sh_blank;
            pattern_err <= r_sh_err;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed testbench for seg_scan_decoder (STABLE_CYC=4, TIMEOUT_CYC=100).
module tb_seg_scan_decoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] anodos = 4'b1111;
   logic [7:0] catodos = 8'hFF;
   logic [3:0] digit3, digit2, digit1, digit0;
   logic [3:0] dp_out, blank, pattern_err;
   logic       frame_valid, scan_lost;

   int n_tests = 0;
   int n_fail  = 0;
   int fv_cnt  = 0;
   int base;

   seg_scan_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
      .clock(clock), .reset(reset), .anodos(anodos), .catodos(catodos),
      .digit3(digit3), .digit2(digit2), .digit1(digit1), .digit0(digit0),
      .dp_out(dp_out), .blank(blank), .pattern_err(pattern_err),
      .frame_valid(frame_valid), .scan_lost(scan_lost));

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
      if (frame_valid) fv_cnt++;
   endtask

   task automatic hold(input logic [3:0] a, input logic [7:0] c, input int n);
      anodos = a;
      catodos = c;
      repeat (n) tick();
   endtask

   task automatic frame(input logic [7:0] c0, input logic [7:0] c1,
                        input logic [7:0] c2, input logic [7:0] c3);
      hold(4'b1110, c0, 10);
      hold(4'b1101, c1, 10);
      hold(4'b1011, c2, 10);
      hold(4'b0111, c3, 10);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      hold(4'b1111, 8'hFF, 3);
      n_tests++;
      if ({digit3, digit2, digit1, digit0, dp_out, blank, pattern_err, frame_valid, scan_lost} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_state got %h expected 0", {digit3, digit2, digit1, digit0, dp_out, blank, pattern_err, frame_valid, scan_lost});
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      base = fv_cnt;
      hold(4'b1110, 8'hC0, 10);
      hold(4'b1101, 8'hF9, 10);
      hold(4'b1011, 8'hA4, 10);
      anodos = 4'b0111;
      catodos = 8'h92;
      for (int i = 1; i <= 10; i++) begin
         tick();
         n_tests++;
         if (frame_valid !== (i == 6)) begin
            n_fail++;
            $display("FAIL basic_fv_latency tick %0d got %b expected %b", i, frame_valid, (i == 6));
         end
      end
      n_tests++;
      if ({digit3, digit2, digit1, digit0} !== 16'h5210) begin
         n_fail++;
         $display("FAIL basic_digits got %h expected 5210", {digit3, digit2, digit1, digit0});
      end
      n_tests++;
      if ({dp_out, blank, pattern_err} !== 12'h000) begin
         n_fail++;
         $display("FAIL basic_flags got %h expected 000", {dp_out, blank, pattern_err});
      end
      n_tests++;
      if (fv_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL basic_fv_count got %0d expected 1", fv_cnt - base);
      end
   endtask

   task automatic test_decode();
      base = fv_cnt;
      frame(8'h40, 8'hFF, 8'hFE, 8'h88);
      n_tests++;
      if ({digit3, digit2, digit1, digit0} !== 16'hA000) begin
         n_fail++;
         $display("FAIL decode_digits got %h expected A000", {digit3, digit2, digit1, digit0});
      end
      n_tests++;
      if ({dp_out, blank, pattern_err} !== {4'b0001, 4'b0010, 4'b0100}) begin
         n_fail++;
         $display("FAIL decode_flags got %b expected 000100100100", {dp_out, blank, pattern_err});
      end
      n_tests++;
      if (fv_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL decode_fv_count got %0d expected 1", fv_cnt - base);
      end
   endtask

   task automatic test_unstable();
      base = fv_cnt;
      for (int i = 0; i < 5; i++) begin
         hold(4'b1110, 8'hF9, 3);
         hold(4'b1101, 8'h99, 3);
      end
      hold(4'b1100, 8'hC0, 20);
      hold(4'b1011, 8'hA4, 10);
      hold(4'b0111, 8'h92, 10);
      n_tests++;
      if (fv_cnt !== base) begin
         n_fail++;
         $display("FAIL unstable_no_capture got %0d frames expected 0", fv_cnt - base);
      end
      hold(4'b1110, 8'hF9, 10);
      hold(4'b1101, 8'h99, 10);
      n_tests++;
      if (fv_cnt - base !== 1) begin
         n_fail++;
         $display("FAIL unstable_complete got %0d frames expected 1", fv_cnt - base);
      end
      n_tests++;
      if ({digit3, digit2, digit1, digit0} !== 16'h5241) begin
         n_fail++;
         $display("FAIL unstable_digits got %h expected 5241", {digit3, digit2, digit1, digit0});
      end
   endtask

   task automatic test_timeout();
      base = fv_cnt;
      hold(4'b1110, 8'hF8, 10);
      hold(4'b1101, 8'hF8, 10);
      hold(4'b1011, 8'hF8, 10);
      anodos = 4'b1111;
      catodos = 8'hFF;
      for (int i = 1; i <= 95; i++) begin
         tick();
         if (i == 94 || i == 95) begin
            n_tests++;
            if (scan_lost !== (i == 95)) begin
               n_fail++;
               $display("FAIL timeout_assert tick %0d got %b expected %b", i, scan_lost, (i == 95));
            end
         end
      end
      n_tests++;
      if ({digit3, digit2, digit1, digit0} !== 16'h5241) begin
         n_fail++;
         $display("FAIL timeout_hold_outputs got %h expected 5241", {digit3, digit2, digit1, digit0});
      end
      anodos = 4'b0111;
      catodos = 8'h80;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (i == 4 || i == 5) begin
            n_tests++;
            if (scan_lost !== (i == 4)) begin
               n_fail++;
               $display("FAIL timeout_release tick %0d got %b expected %b", i, scan_lost, (i == 4));
            end
         end
      end
      n_tests++;
      if (fv_cnt !== base) begin
         n_fail++;
         $display("FAIL timeout_mask_cleared got %0d frames expected 0", fv_cnt - base);
      end
      hold(4'b1110, 8'hC6, 10);
      hold(4'b1101, 8'hA1, 10);
      hold(4'b1011, 8'h86, 10);
      n_tests++;
      if (fv_cnt - base !== 1 || {digit3, digit2, digit1, digit0} !== 16'h8EDC) begin
         n_fail++;
         $display("FAIL timeout_next_frame got %0d frames digits %h expected 1 frames digits 8EDC", fv_cnt - base, {digit3, digit2, digit1, digit0});
      end
   endtask

   task automatic test_reset_midframe();
      hold(4'b1110, 8'h8E, 10);
      hold(4'b1101, 8'h83, 10);
      reset = 1'b1;
      hold(4'b1111, 8'hFF, 2);
      reset = 1'b0;
      n_tests++;
      if ({digit3, digit2, digit1, digit0} !== 16'h0000) begin
         n_fail++;
         $display("FAIL midreset_clear got %h expected 0000", {digit3, digit2, digit1, digit0});
      end
      base = fv_cnt;
      hold(4'b1011, 8'hB0, 10);
      hold(4'b0111, 8'h99, 10);
      n_tests++;
      if (fv_cnt !== base) begin
         n_fail++;
         $display("FAIL midreset_partial got %0d frames expected 0", fv_cnt - base);
      end
      hold(4'b1110, 8'h82, 10);
      hold(4'b1101, 8'h90, 10);
      n_tests++;
      if (fv_cnt - base !== 1 || {digit3, digit2, digit1, digit0} !== 16'h4396) begin
         n_fail++;
         $display("FAIL midreset_frame got %0d frames digits %h expected 1 frames digits 4396", fv_cnt - base, {digit3, digit2, digit1, digit0});
      end
   endtask

   task automatic test_back_to_back();
      base = fv_cnt;
      frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
      frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
      n_tests++;
      if (fv_cnt - base !== 2) begin
         n_fail++;
         $display("FAIL back_to_back got %0d frames expected 2", fv_cnt - base);
      end
   endtask

   task automatic test_compare();
      base = fv_cnt;
      frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
      tick();
      n_tests++;
      if (fv_cnt !== base) begin
         n_fail++;
         $display("FAIL compare_first got %0d frames expected 0", fv_cnt - base);
      end
      frame(8'hC0, 8'hF9, 8'hA4, 8'h92);
      tick();
      n_tests++;
      if (fv_cnt - base !== 1 || {digit3, digit2, digit1, digit0} !== 16'h5210) begin
         n_fail++;
         $display("FAIL compare_second got %0d frames digits %h expected 1 frames digits 5210", fv_cnt - base, {digit3, digit2, digit1, digit0});
      end
      frame(8'hC0, 8'hF9, 8'hA4, 8'h82);
      tick();
      n_tests++;
      if (fv_cnt - base !== 1 || {digit3, digit2, digit1, digit0} !== 16'h5210) begin
         n_fail++;
         $display("FAIL compare_third got %0d frames digits %h expected 1 frames digits 5210", fv_cnt - base, {digit3, digit2, digit1, digit0});
      end
   endtask

   initial begin
      test_reset();
`ifdef SEG_FRAME_COMPARE_EN
      test_compare();
`else
      test_basic();
      test_decode();
      test_unstable();
      test_timeout();
      test_reset_midframe();
      test_back_to_back();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYC, default 4, cycles anodos/catodos must hold unchanged before a digit is captured (range 1..255).
REQ-002 Parameter TIMEOUT_CYC, default 50000, cycles without any capture before scan_lost asserts (range 2..65535).
REQ-003 Port clock  in  1  single system clock; all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Port anodos  in  4  multiplexed display digit enables, active-low one-hot; bit n selects digit n.
REQ-006 Port catodos  in  8  segment lines, active-low; [6:0] = g,f,e,d,c,b,a; [7] = dp.
REQ-007 Port digit3..digit0  out  4 each  decoded hex value of each digit, updated only on frame_valid.
REQ-008 Port dp_out  out  4  decimal-point state per digit, 1 = lit, updated on frame_valid.
REQ-009 Port blank  out  4  per-digit flag, 1 = all seven segments off, updated on frame_valid.
REQ-010 Port pattern_err  out  4  per-digit flag, 1 = segment pattern not a hex glyph and not blank, updated on frame_valid.
REQ-011 Port frame_valid  out  1  one-cycle pulse when a complete four-digit frame is published.
REQ-012 Port scan_lost  out  1  level, 1 = no capture for TIMEOUT_CYC cycles.

Function
REQ-013 A sample {anodos,catodos} differing from the previous cycle's sample SHALL reset the stability counter to 0; otherwise the counter SHALL increment, saturating at STABLE_CYC.
REQ-014 When the counter reaches STABLE_CYC with anodos one-hot-low, the digit SHALL be captured exactly once per stable period, into shadow registers for that index.
REQ-015 anodos equal to 4'b1111, or with more than one bit low, SHALL never cause a capture and SHALL not alter the shadow registers.
REQ-016 Decode: standard hex glyphs (0-9, A, b, C, d, E, F) SHALL map to 0x0-0xF; all-off SHALL set blank with value 0; any other pattern SHALL set pattern_err with value 0.
REQ-017 Re-capturing an already captured index within the same frame SHALL overwrite its shadow value.
REQ-018 A four-bit captured mask SHALL track captured indices; when the mask becomes 4'b1111, the next cycle SHALL copy shadows to outputs, pulse frame_valid, and clear the mask in that same cycle.
REQ-019 Latency: frame_valid SHALL assert exactly 1 cycle after the capture completing the mask.
REQ-020 A timeout counter SHALL clear on every capture and increment otherwise, saturating; scan_lost SHALL be 1 while the count is >= TIMEOUT_CYC.
REQ-021 On scan_lost assertion, the captured mask SHALL clear; published outputs SHALL hold their last values.
REQ-022 A capture and a timeout in the same cycle: the capture SHALL win (counter cleared, scan_lost deasserts the next cycle).

Reset
REQ-023 When reset=1 at a clock edge: digits, dp_out, blank, pattern_err = 0; frame_valid = 0; scan_lost = 0; mask, shadows, and both counters = 0.
REQ-024 Reset mid-frame SHALL discard partial captures; the first frame after reset requires four fresh captures.

Configuration
REQ-025 Macro SEG_FRAME_COMPARE_EN defined: a completed frame SHALL be published only if its digits, dp, blank, and err equal the previous completed frame; otherwise it SHALL be stored as the comparison reference without a frame_valid pulse (first frame after reset or scan_lost is never published).
REQ-026 Macro SEG_FRAME_COMPARE_EN undefined: every completed frame SHALL be published per REQ-018; no comparison storage SHALL exist.

Verification
REQ-027 STABLE_CYC=4; anodos 1110/1101/1011/0111 with catodos 0xC0, 0xF9, 0xA4, 0x92, each held 10 cycles -> digits 0,1,2,5; frame_valid single pulse 1 cycle after the 4th capture.
REQ-028 catodos 0x40 on digit0 -> dp_out[0]=1, digit0=0; catodos 0xFF -> blank=1; catodos 0xFE (only segment a lit) -> pattern_err=1, value 0.
REQ-029 Sample toggling every 3 cycles with STABLE_CYC=4 -> no capture, no frame_valid; anodos 1100 held 20 cycles -> no capture.
REQ-030 No anode activity for TIMEOUT_CYC=100 cycles -> scan_lost=1 at count 100, outputs unchanged; next capture -> scan_lost=0 one cycle later.
REQ-031 Reset asserted after 2 captures, then 4 captures -> exactly one frame_valid, showing only post-reset values.
REQ-032 With SEG_FRAME_COMPARE_EN: frames 0125, 0125, 0126 -> one frame_valid, after the 2nd frame; 0126 not published.
